// File: rtl/csr_regfile_if.sv
// Writeback/decode/fetch-facing signal bundle for the CSR register file.
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  modport master (
    output csr_rnum, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr,
           ertn_flush, hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_entry, has_int
  );

  modport slave (
    input  csr_rnum, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr,
           ertn_flush, hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_entry, has_int
  );
endinterface

// File: rtl/csr_regfile.sv
// CSR register file: masked writes, exception/ertn state updates, interrupt
// sampling and the constant timer.
module csr_regfile #(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic          clk,
  input  logic          resetn,
  csr_regfile_if.slave  csr
);

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  typedef enum logic {TMR_IDLE, TMR_ARMED} tmr_state_e;

  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d, crmd_da_q, crmd_da_d, crmd_pg_q, crmd_pg_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [12:0] ecfg_lie_q, ecfg_lie_d;
  logic [12:0] estat_is_q, estat_is_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [31:0] era_q, era_d, badv_q, badv_d;
  logic [25:0] eentry_va_q, eentry_va_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
  tmr_state_e  tmr_q, tmr_d;

  logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd;
  logic [31:0] wmerge;
  logic        wr_en, ertn_en, tcfg_wr, ticlr_wr, tmr_zero;

  assign crmd_rd   = {27'b0, crmd_pg_q, crmd_da_q, crmd_ie_q, crmd_plv_q};
  assign prmd_rd   = {29'b0, prmd_pie_q, prmd_pplv_q};
  assign ecfg_rd   = {19'b0, ecfg_lie_q};
  assign estat_rd  = {1'b0, estat_esub_q, estat_ecode_q, 3'b0, estat_is_q};
  assign eentry_rd = {eentry_va_q, 6'b0};

  always_comb begin
    csr.csr_rvalue = '0;
    case (csr.csr_rnum)
      A_CRMD:   csr.csr_rvalue = crmd_rd;
      A_PRMD:   csr.csr_rvalue = prmd_rd;
      A_ECFG:   csr.csr_rvalue = ecfg_rd;
      A_ESTAT:  csr.csr_rvalue = estat_rd;
      A_ERA:    csr.csr_rvalue = era_q;
      A_BADV:   csr.csr_rvalue = badv_q;
      A_EENTRY: csr.csr_rvalue = eentry_rd;
      A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: csr.csr_rvalue = save_q[csr.csr_rnum[1:0]];
      A_TID:    csr.csr_rvalue = tid_q;
      A_TCFG:   csr.csr_rvalue = tcfg_q;
      A_TVAL:   csr.csr_rvalue = tval_q;
      default:  csr.csr_rvalue = '0;
    endcase
  end

  assign csr.has_int    = crmd_ie_q & (|(estat_is_q & ecfg_lie_q));
  assign csr.ex_entry   = eentry_rd;
  assign csr.ertn_entry = era_q;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    crmd_plv_d = crmd_plv_q;   crmd_ie_d = crmd_ie_q;
    crmd_da_d  = crmd_da_q;    crmd_pg_d = crmd_pg_q;
    prmd_pplv_d = prmd_pplv_q; prmd_pie_d = prmd_pie_q;
    ecfg_lie_d = ecfg_lie_q;   estat_is_d = estat_is_q;
    estat_ecode_d = estat_ecode_q; estat_esub_d = estat_esub_q;
    era_d = era_q;  badv_d = badv_q;  eentry_va_d = eentry_va_q;
    save_d = save_q;
    tid_d = tid_q;  tcfg_d = tcfg_q;  tval_d = tval_q;  tmr_d = tmr_q;
    wmerge   = '0;
    tcfg_wr  = 1'b0;
    ticlr_wr = 1'b0;
    wr_en    = csr.csr_we & ~csr.wb_ex;
    ertn_en  = csr.ertn_flush & ~csr.wb_ex;
    tmr_zero = (tmr_q == TMR_ARMED) && (tval_q == '0);

    if (wr_en) begin
      case (csr.csr_num)
        A_CRMD: begin
          wmerge = merge(crmd_rd, csr.csr_wvalue, csr.csr_wmask);
          crmd_plv_d = wmerge[1:0];
          crmd_ie_d  = wmerge[2];
          crmd_da_d  = wmerge[3];
          crmd_pg_d  = wmerge[4];
        end
        A_PRMD: begin
          wmerge = merge(prmd_rd, csr.csr_wvalue, csr.csr_wmask);
          prmd_pplv_d = wmerge[1:0];
          prmd_pie_d  = wmerge[2];
        end
        A_ECFG: begin
          wmerge = merge(ecfg_rd, csr.csr_wvalue, csr.csr_wmask);
          ecfg_lie_d = wmerge[12:0] & 13'h1BFF;
        end
        A_ESTAT: begin
          wmerge = merge(estat_rd, csr.csr_wvalue, csr.csr_wmask);
          estat_is_d[1:0] = wmerge[1:0];
        end
        A_ERA:  era_d  = merge(era_q, csr.csr_wvalue, csr.csr_wmask);
        A_BADV: badv_d = merge(badv_q, csr.csr_wvalue, csr.csr_wmask);
        A_EENTRY: begin
          wmerge = merge(eentry_rd, csr.csr_wvalue, csr.csr_wmask);
          eentry_va_d = wmerge[31:6];
        end
        A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
          save_d[csr.csr_num[1:0]] = merge(save_q[csr.csr_num[1:0]], csr.csr_wvalue, csr.csr_wmask);
        A_TID:  tid_d = merge(tid_q, csr.csr_wvalue, csr.csr_wmask);
        A_TCFG: begin
          tcfg_d  = merge(tcfg_q, csr.csr_wvalue, csr.csr_wmask);
          tcfg_wr = 1'b1;
        end
        A_TICLR: ticlr_wr = csr.csr_wvalue[0] & csr.csr_wmask[0];
        default: ;
      endcase
    end

    // ertn is applied after the write so it owns PLV/IE when both occur
    if (ertn_en) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end

    if (csr.wb_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = '0;
      crmd_ie_d     = 1'b0;
      estat_ecode_d = csr.wb_ecode;
      estat_esub_d  = csr.wb_esubcode;
      era_d         = csr.wb_pc;
      if (csr.wb_ecode == 6'h08)      badv_d = csr.wb_pc;
      else if (csr.wb_ecode == 6'h09) badv_d = csr.wb_badvaddr;
    end

    estat_is_d[9:2] = csr.hw_int_in;
    estat_is_d[12]  = csr.ipi_int_in;

    if (tcfg_wr) begin
      if (tcfg_d[0]) begin
        tmr_d  = TMR_ARMED;
        tval_d = {tcfg_d[31:2], 2'b00};
      end else begin
        tmr_d  = TMR_IDLE;
      end
    end else if (tmr_q == TMR_ARMED) begin
      if (tval_q != '0)   tval_d = tval_q - 32'd1;
      else if (tcfg_q[1]) tval_d = {tcfg_q[31:2], 2'b00};
      else                tmr_d  = TMR_IDLE;
    end

    if (tmr_zero)      estat_is_d[11] = 1'b1;
    else if (ticlr_wr) estat_is_d[11] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv_q <= '0;  crmd_ie_q <= 1'b0;  crmd_da_q <= 1'b1;  crmd_pg_q <= 1'b0;
      prmd_pplv_q <= '0; prmd_pie_q <= 1'b0;
      ecfg_lie_q <= '0;  estat_is_q <= '0;
      estat_ecode_q <= '0; estat_esub_q <= '0;
      era_q <= '0;  badv_q <= '0;  eentry_va_q <= '0;
      save_q <= '{default: '0};
      tid_q <= TID_INIT;  tcfg_q <= '0;  tval_q <= '1;
      tmr_q <= TMR_IDLE;
    end else begin
      crmd_plv_q <= crmd_plv_d;  crmd_ie_q <= crmd_ie_d;
      crmd_da_q  <= crmd_da_d;   crmd_pg_q <= crmd_pg_d;
      prmd_pplv_q <= prmd_pplv_d; prmd_pie_q <= prmd_pie_d;
      ecfg_lie_q <= ecfg_lie_d;  estat_is_q <= estat_is_d;
      estat_ecode_q <= estat_ecode_d; estat_esub_q <= estat_esub_d;
      era_q <= era_d;  badv_q <= badv_d;  eentry_va_q <= eentry_va_d;
      save_q <= save_d;
      tid_q <= tid_d;  tcfg_q <= tcfg_d;  tval_q <= tval_d;
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: directed scenarios plus random traffic
// against an address-indexed register model.
module tb_csr_regfile;

  localparam logic [31:0] TIDV = 32'hA5A5_0001;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  csr_regfile_if bus();

  csr_regfile #(.TID_INIT(TIDV)) dut (
    .clk    (clk),
    .resetn (resetn),
    .csr    (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rv;
    logic        hi;
    logic [31:0] ee;
    logic [31:0] re;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  int unsigned R[int];
  bit armed;

  int unsigned ra[16] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC, 'h30, 'h31, 'h32,
                          'h33, 'h40, 'h41, 'h42, 'h44, 'h2};

  function automatic int unsigned wmask_of(input int unsigned a);
    case (a)
      'h0:  return 32'h0000_001F;
      'h1:  return 32'h0000_0007;
      'h4:  return 32'h0000_1BFF;
      'h5:  return 32'h0000_0003;
      'h6, 'h7, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
      'hC:  return 32'hFFFF_FFC0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int unsigned mread(input int unsigned a);
    if (R.exists(int'(a))) return R[int'(a)];
    return 0;
  endfunction

  function automatic bit m_has_int();
    return ((R[0] & 4) != 0) && ((R[5] & R[4] & 32'h1FFF) != 0);
  endfunction

  task automatic model_reset();
    R.delete();
    foreach (ra[i]) if (ra[i] != 'h44 && ra[i] != 'h2) R[int'(ra[i])] = 0;
    R[0] = 32'h8;
    R['h40] = TIDV;
    R['h42] = 32'hFFFF_FFFF;
    armed = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.name, ".rvalue"},  bus.csr_rvalue,           e.rv);
      chk({e.name, ".has_int"}, {31'b0, bus.has_int},     {31'b0, e.hi});
      chk({e.name, ".ex_ent"},  bus.ex_entry,             e.ee);
      chk({e.name, ".ertn_ent"}, bus.ertn_entry,          e.re);
    end
  end

  task automatic drv_idle();
    bus.csr_we = 1'b0;  bus.csr_num = '0;  bus.csr_wmask = '0;  bus.csr_wvalue = '0;
    bus.wb_ex = 1'b0;   bus.wb_ecode = '0; bus.wb_esubcode = '0;
    bus.wb_pc = '0;     bus.wb_badvaddr = '0;
    bus.ertn_flush = 1'b0;
    bus.csr_rnum = '0;
  endtask

  // One clock: queue the expected view for the current inputs, then advance the model.
  task automatic step(input string nm, input bit uselit, input logic [31:0] lit);
    exp_t e;
    int unsigned N[int];
    bit na, wr, ertn, tw, zero;
    int unsigned a, wm;
    e.name = nm;
    e.rv = uselit ? lit : mread(int'(bus.csr_rnum));
    e.hi = m_has_int();
    e.ee = R['hC];
    e.re = R[6];
    sbq.push_back(e);
    N = R;
    na = armed;
    if (resetn) begin
      a    = int'(bus.csr_num);
      wr   = bus.csr_we && !bus.wb_ex;
      ertn = bus.ertn_flush && !bus.wb_ex;
      wm   = bus.csr_wmask & wmask_of(a);
      if (wr && wmask_of(a) != 0) N[int'(a)] = (R[int'(a)] & ~wm) | (bus.csr_wvalue & wm);
      tw = wr && (a == 'h41);
      if (ertn) N[0] = (N[0] & ~32'h7) | (R[1] & 32'h7);
      if (bus.wb_ex) begin
        N[1] = R[0] & 32'h7;
        N[0] = R[0] & ~32'h7;
        N[5] = (R[5] & 32'h0000_FFFF) | (32'(bus.wb_ecode) << 16) | (32'(bus.wb_esubcode) << 22);
        N[6] = bus.wb_pc;
        if (bus.wb_ecode == 6'h08)      N[7] = bus.wb_pc;
        else if (bus.wb_ecode == 6'h09) N[7] = bus.wb_badvaddr;
      end
      N[5] = (N[5] & ~32'h13FC) | (32'(bus.hw_int_in) << 2) | (32'(bus.ipi_int_in) << 12);
      zero = armed && (R['h42] == 0);
      if (tw) begin
        na = (N['h41] & 1) != 0;
        if (na) N['h42] = N['h41] & ~32'h3;
      end else if (armed) begin
        if (R['h42] != 0)            N['h42] = R['h42] - 1;
        else if ((R['h41] & 2) != 0) N['h42] = R['h41] & ~32'h3;
        else                         na = 1'b0;
      end
      if (zero) N[5] = N[5] | 32'h800;
      else if (wr && a == 'h44 && bus.csr_wvalue[0] && bus.csr_wmask[0]) N[5] = N[5] & ~32'h800;
    end
    @(posedge clk);
    R = N;
    armed = na;
    #1;
  endtask

  task automatic do_wr(input int unsigned num, input logic [31:0] wv, input logic [31:0] wm,
                       input int unsigned rnum, input string nm,
                       input bit uselit = 1'b0, input logic [31:0] lit = '0);
    drv_idle();
    bus.csr_we = 1'b1;  bus.csr_num = 14'(num);
    bus.csr_wvalue = wv; bus.csr_wmask = wm;
    bus.csr_rnum = 14'(rnum);
    step(nm, uselit, lit);
  endtask

  task automatic do_rd(input int unsigned rnum, input string nm,
                       input bit uselit = 1'b0, input logic [31:0] lit = '0);
    drv_idle();
    bus.csr_rnum = 14'(rnum);
    step(nm, uselit, lit);
  endtask

  initial begin
    resetn = 1'b0;
    drv_idle();
    bus.hw_int_in = '0;
    bus.ipi_int_in = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_rd('h0,  "rst_crmd",  1, 32'h8);
    do_rd('h5,  "rst_estat", 1, 32'h0);
    do_rd('h42, "rst_tval",  1, 32'hFFFF_FFFF);
    do_rd('h40, "rst_tid",   1, TIDV);
    resetn = 1'b1;

    do_wr('h31, 32'h1234_5678, 32'hFFFF_FFFF, 'h31, "save1_init");
    do_wr('h31, 32'hDEAD_BEEF, 32'h0000_FFFF, 'h31, "save1_same_cyc", 1, 32'h1234_5678);
    do_rd('h31, "save1_masked", 1, 32'h1234_BEEF);

    do_wr('h0, 32'h7, 32'h7, 'h0, "crmd_set");
    drv_idle();
    bus.wb_ex = 1'b1;  bus.wb_ecode = 6'h09;  bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h1C00_0100;  bus.wb_badvaddr = 32'h0000_0003;
    bus.csr_we = 1'b1;  bus.csr_num = 14'h31;  bus.csr_wmask = '1;  bus.csr_wvalue = '0;
    bus.csr_rnum = 14'h0;
    step("ex_commit", 1, 32'hF);
    do_rd('h1,  "ex_prmd",  1, 32'h7);
    do_rd('h0,  "ex_crmd",  1, 32'h8);
    do_rd('h6,  "ex_era",   1, 32'h1C00_0100);
    do_rd('h7,  "ex_badv",  1, 32'h3);
    do_rd('h5,  "ex_estat", 1, 32'h0009_0000);
    do_rd('h31, "ex_we_ignored", 1, 32'h1234_BEEF);

    drv_idle();
    bus.ertn_flush = 1'b1;
    step("ertn", 1, 32'h8);
    do_rd('h0, "ertn_crmd", 1, 32'hF);

    do_wr('h4, 32'h800, 32'h800, 'h4, "lie11");
    do_wr('h41, 32'h9, 32'hFFFF_FFFF, 'h42, "tcfg_oneshot", 1, 32'hFFFF_FFFF);
    for (int k = 8; k >= 0; k--) do_rd('h42, $sformatf("tval_%0d", k), 1, 32'(k));
    do_rd('h5,  "timer_is11", 1, 32'h0009_0800);
    do_rd('h42, "tval_hold",  1, 32'h0);
    do_rd('h42, "tval_hold2", 1, 32'h0);
    do_wr('h44, 32'h1, 32'h1, 'h44, "ticlr", 1, 32'h0);
    do_rd('h5,  "ticlr_done", 1, 32'h0009_0000);

    do_wr('h41, 32'hB, 32'hFFFF_FFFF, 'h42, "tcfg_periodic");
    for (int k = 0; k < 22; k++) do_rd('h42, "periodic");
    do_wr('h41, 32'h0, 32'hFFFF_FFFF, 'h42, "tcfg_off");
    do_wr('h44, 32'h1, 32'h1, 'h5, "ticlr2");

    do_wr('h4, 32'h4, 32'h4, 'h4, "lie2");
    bus.hw_int_in = 8'h01;
    do_rd('h5, "hw_on");
    do_rd('h5, "hw_seen");
    bus.hw_int_in = 8'h00;
    do_rd('h5, "hw_off");
    do_rd('h5, "hw_gone");

    do_wr('h41, 32'h41, 32'hFFFF_FFFF, 'h42, "arm_pre_rst");
    do_rd('h42, "armed_a");
    do_rd('h42, "armed_b");
    resetn = 1'b0;
    model_reset();
    do_rd('h42, "rst_async_tval", 1, 32'hFFFF_FFFF);
    resetn = 1'b1;
    do_rd('h42, "post_rst_tval", 1, 32'hFFFF_FFFF);
    do_rd('h0,  "post_rst_crmd", 1, 32'h8);

    for (int c = 0; c < 3000; c++) begin
      drv_idle();
      if ($urandom_range(0, 9) < 4) begin
        bus.csr_we = 1'b1;
        bus.csr_num = 14'(ra[$urandom_range(0, 15)]);
        bus.csr_wvalue = $urandom;
        bus.csr_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
        if (bus.csr_num == 14'h41) bus.csr_wvalue = bus.csr_wvalue & 32'h3F;
      end
      if ($urandom_range(0, 19) == 0) begin
        int unsigned sel;
        sel = $urandom_range(0, 2);
        bus.wb_ex = 1'b1;
        bus.wb_ecode = (sel == 0) ? 6'h08 : (sel == 1) ? 6'h09 : 6'($urandom);
        bus.wb_esubcode = 9'($urandom);
        bus.wb_pc = $urandom;
        bus.wb_badvaddr = $urandom;
      end
      bus.ertn_flush = ($urandom_range(0, 19) == 0);
      bus.hw_int_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      bus.ipi_int_in = ($urandom_range(0, 7) == 0);
      bus.csr_rnum   = 14'(ra[$urandom_range(0, 15)]);
      step("rand", 0, '0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file at the receiving end of the writeback-to-CSR interface.
- Accepts masked CSR writes, exception commits (wb_ex/ecode/esubcode/pc/badvaddr) and ertn_flush from writeback.
- Serves combinational CSR reads to decode, supplies exception/return entry PCs to fetch, and raises the interrupt request.
- Owns the constant timer.

Parameters:
- TID_INIT, 32'h0, reset value of TID.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous assertion, active-low
- csr_rnum  in  14  read address
- csr_rvalue  out  32  read data, combinational; unimplemented address reads 0
- csr_we  in  1  write enable
- csr_num  in  14  write address
- csr_wmask  in  32  bit write mask
- csr_wvalue  in  32  write data
- wb_ex  in  1  exception commit
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_pc  in  32  PC of excepting instruction
- wb_badvaddr  in  32  faulting data address
- ertn_flush  in  1  ertn commit
- hw_int_in  in  8  hardware interrupt lines, level
- ipi_int_in  in  1  inter-processor interrupt, level
- ex_entry  out  32  exception handler PC, equals EENTRY
- ertn_entry  out  32  return PC, equals ERA
- has_int  out  1  pending enabled interrupt

Behaviour:
- Registers, addresses and fields:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[9:0], LIE[12:11]. Bit 10 reads 0.
  - ESTAT 0x5:
    - IS[1:0]: software-writable.
    - IS[9:2]: hw.
    - IS[11]: timer.
    - IS[12]: ipi.
    - Ecode[21:16], EsubCode[30:22].
  - ERA 0x6.
  - BADV 0x7.
  - EENTRY 0xC: VA[31:6]; [5:0] read 0.
  - SAVE0-3 0x30-0x33.
  - TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: reads 0.
- Unlisted bits are read-only zero.
- Reset values (async):
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - TID = TID_INIT.
  - TVAL = 32'hFFFFFFFF.
  - Timer disarmed.
  - All other state 0.
  - Outputs follow: has_int=0, ex_entry=0, ertn_entry=0.
- CSR write, one-cycle latency: field <= (old & ~wmask) | (wvalue & wmask), writable bits only. A read in the same cycle returns the old value.
- ESTAT writes touch IS[1:0] only.
- TICLR write with wvalue[0]&wmask[0] clears IS[11] next cycle.
- Exception commit (wb_ex=1), all next cycle:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - ESTAT.Ecode<=wb_ecode; ESTAT.EsubCode<=wb_esubcode.
  - ERA<=wb_pc.
  - BADV: ecode 0x08 (ADE) loads wb_pc; ecode 0x09 (ALE) loads wb_badvaddr; other codes leave it unchanged.
- ertn_flush=1: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- Priority:
  - wb_ex overrides ertn_flush and csr_we; both are ignored that cycle.
  - ertn_flush with csr_we: ertn owns CRMD.PLV/IE; the write applies to all other fields.
- Interrupt sampling: IS[9:2]<=hw_int_in and IS[12]<=ipi_int_in every cycle, one-cycle latency.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational from registers.
- Timer:
  - Arming: a TCFG write whose resulting En=1 arms the timer and loads TVAL<={new InitVal,2'b00} next cycle. A write with En=0 disarms it; TVAL holds.
  - Armed, TVAL!=0: TVAL decrements by 1 per cycle.
  - Armed, TVAL==0: IS[11]<=1. If Periodic, TVAL reloads {InitVal,2'b00}. Otherwise the timer disarms and TVAL stays 0 (TCFG.En readback unchanged).
  - Timer set and TICLR clear in the same cycle: set wins.
  - TCFG write in the same cycle as a zero-reach: the write (re-arm/load) wins; IS[11] still sets.
- TID is writable and has no other behaviour.
- Reset mid-operation clears all state immediately, including an armed timer.

Test Plan:
- Reset → csr_rvalue(0x0)=32'h8, ESTAT=0, TVAL=32'hFFFFFFFF, has_int=0.
- Masked write: write SAVE1 wvalue=32'hDEADBEEF, wmask=32'h0000FFFF over 32'h12345678 → reads 32'h1234BEEF next cycle; same-cycle read returns 32'h12345678.
- Exception:
  - Setup: CRMD.PLV=3, IE=1.
  - Stimulus: wb_ex with ecode 0x09, wb_pc=32'h1C000100, badvaddr=32'h00000003.
  - Response: PRMD=32'h7, CRMD.PLV=0/IE=0, ERA=32'h1C000100, BADV=32'h3, ESTAT[21:16]=0x09. A csr_we in the same cycle has no effect.
- ertn: after the exception above, ertn_flush → CRMD.PLV=3, IE=1; ertn_entry=32'h1C000100.
- Timer, one-shot:
  - Setup: ECFG.LIE[11]=1, CRMD.IE=1.
  - Stimulus: write TCFG=32'h9 (InitVal=2, one-shot).
  - Response: TVAL 8→0 over 8 cycles. IS[11]=1 and has_int=1 the cycle after TVAL reaches 0. TVAL then holds 0. A TICLR write of 1 drops has_int the next cycle.
  - Periodic variant (TCFG=32'hB): TVAL reloads 8 after 0, with a repeat interrupt every 9 cycles.
- hw_int_in=8'h01 with LIE[2]=1, IE=1 → has_int rises one cycle later and falls one cycle after hw_int_in drops.
